// File: rtl/mmcb_mem_responder.sv
// mmcb_mem_responder: dual-port fixed-latency magic-memory responder (port A = fetch, port B = load/store).
// Define MMCB_RAND_STALL_EN to add 0..3 LFSR-driven extra wait cycles per transaction.
module mmcb_mem_responder #(
   parameter int    DEPTH_WORDS = 1024,
   parameter int    LATENCY     = 2,
   parameter string INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address_a,
   input  logic        read_a,
   output logic [31:0] rdata_a,
   output logic        resp_a,
   input  logic [31:0] address_b,
   input  logic        read_b,
   input  logic        write,
   input  logic [3:0]  data_mbe,
   input  logic [31:0] wdata,
   output logic [31:0] rdata_b,
   output logic        resp_b,
   output logic        proto_err
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int NP    = 2;
`ifdef MMCB_RAND_STALL_EN
   localparam int CNT_W = 5;
`else
   localparam int CNT_W = 4;
`endif

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   logic [31:0]              mem_q [DEPTH_WORDS];
   state_t                   state_q [NP];
   state_t                   state_d [NP];
   logic [NP-1:0][CNT_W-1:0] cnt_q, cnt_d, cnt_init;
   logic [NP-1:0][IDX_W-1:0] idx_q, idx_d, cur_idx, in_idx;
   logic [NP-1:0][31:0]      rdata_q, rdata_d;
   logic [NP-1:0]            req, hold, accept, fire;
   logic                     st_q, st_d, cur_st;
   logic [3:0]               mbe_q, mbe_d, cur_mbe;
   logic [31:0]              wdata_q, wdata_d, cur_wdata, merged;
   logic                     proto_err_q, proto_err_d;
   logic                     unused_addr;

   assign unused_addr = ^{address_a[31:IDX_W+2], address_a[1:0], address_b[31:IDX_W+2], address_b[1:0]};

`ifdef MMCB_RAND_STALL_EN
   localparam logic [NP-1:0][7:0] LFSR_SEED = {8'h3C, 8'hA5};
   logic [NP-1:0][7:0] lfsr_q, lfsr_d;

   always_comb begin
      for (int p = 0; p < NP; p++)
         lfsr_d[p] = {lfsr_q[p][6:0], lfsr_q[p][7] ^ lfsr_q[p][5] ^ lfsr_q[p][4] ^ lfsr_q[p][3]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= LFSR_SEED;
      else     lfsr_q <= lfsr_d;
   end
`endif

   always_comb begin
      req         = {read_b | write, read_a};
      hold        = {(st_q ? write : read_b), read_a};
      in_idx[0]   = address_a[IDX_W+1:2];
      in_idx[1]   = address_b[IDX_W+1:2];
      accept      = '0;
      fire        = '0;
      proto_err_d = proto_err_q;
      for (int p = 0; p < NP; p++) begin
         state_d[p]  = state_q[p];
         cnt_d[p]    = cnt_q[p];
         idx_d[p]    = idx_q[p];
         cnt_init[p] = CNT_W'(LATENCY - 1);
`ifdef MMCB_RAND_STALL_EN
         cnt_init[p] = cnt_init[p] + CNT_W'(lfsr_q[p][1:0]);
`endif
         unique case (state_q[p])
            S_IDLE: begin
               if (req[p]) begin
                  accept[p] = 1'b1;
                  idx_d[p]  = in_idx[p];
                  cnt_d[p]  = cnt_init[p];
                  if (cnt_init[p] == '0) begin
                     state_d[p] = S_RESP;
                     fire[p]    = 1'b1;
                  end else begin
                     state_d[p] = S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               cnt_d[p] = cnt_q[p] - CNT_W'(1);
               // Dropping the request mid-flight is flagged, but the transaction still completes.
               if (!hold[p]) proto_err_d = 1'b1;
               if (cnt_q[p] == CNT_W'(1)) begin
                  state_d[p] = S_RESP;
                  fire[p]    = 1'b1;
               end
            end
            S_RESP:  state_d[p] = S_IDLE;
            default: state_d[p] = S_IDLE;
         endcase
         // With a one-cycle path the accept and RESP edges coincide, so use live inputs.
         cur_idx[p] = accept[p] ? in_idx[p] : idx_q[p];
      end
      cur_st    = accept[1] ? write    : st_q;
      cur_mbe   = accept[1] ? data_mbe : mbe_q;
      cur_wdata = accept[1] ? wdata    : wdata_q;
      st_d      = cur_st;
      mbe_d     = cur_mbe;
      wdata_d   = cur_wdata;
      if (accept[1] && read_b && write) proto_err_d = 1'b1;
   end

   always_comb begin
      merged = mem_q[cur_idx[1]];
      for (int i = 0; i < 4; i++)
         if (cur_mbe[i]) merged[8*i +: 8] = cur_wdata[8*i +: 8];
   end

   // Same-word same-edge fetch sees the store's merged word (write-first).
   always_comb begin
      rdata_d = '0;
      if (fire[0])
         rdata_d[0] = (fire[1] && cur_st && (cur_idx[1] == cur_idx[0])) ? merged : mem_q[cur_idx[0]];
      if (fire[1] && !cur_st)
         rdata_d[1] = mem_q[cur_idx[1]];
   end

   always_ff @(posedge clk) begin
      if (fire[1] && cur_st && !rst) mem_q[cur_idx[1]] <= merged;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < NP; p++) state_q[p] <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         rdata_q     <= '0;
         st_q        <= 1'b0;
         mbe_q       <= '0;
         wdata_q     <= '0;
         proto_err_q <= 1'b0;
      end else begin
         for (int p = 0; p < NP; p++) state_q[p] <= state_d[p];
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         rdata_q     <= rdata_d;
         st_q        <= st_d;
         mbe_q       <= mbe_d;
         wdata_q     <= wdata_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign resp_a    = (state_q[0] == S_RESP);
   assign resp_b    = (state_q[1] == S_RESP);
   assign rdata_a   = rdata_q[0];
   assign rdata_b   = rdata_q[1];
   assign proto_err = proto_err_q;
endmodule

// File: tb/tb_mmcb_mem_responder.sv
// Bench for mmcb_mem_responder: directed handshake cases plus randomized dual-port traffic
// checked against a word-array model with fixed-latency timing.
module tb_mmcb_mem_responder;
   localparam int LAT   = 2;
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] address_a = '0, address_b = '0, wdata = '0;
   logic        read_a = 1'b0, read_b = 1'b0, write = 1'b0;
   logic [3:0]  data_mbe = '0;
   logic [31:0] rdata_a, rdata_b;
   logic        resp_a, resp_b, proto_err;

   logic        read_a1 = 1'b0;
   logic [31:0] rdata_a1, rdata_b1;
   logic        resp_a1, resp_b1, perr1;

   int ncmp  = 0;
   int nfail = 0;
   logic [31:0] mdl [DEPTH];

   always #5 clk = ~clk;

   mmcb_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .address_a(address_a), .read_a(read_a), .rdata_a(rdata_a), .resp_a(resp_a),
      .address_b(address_b), .read_b(read_b), .write(write), .data_mbe(data_mbe),
      .wdata(wdata), .rdata_b(rdata_b), .resp_b(resp_b), .proto_err(proto_err));

   mmcb_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst),
      .address_a(32'h0), .read_a(read_a1), .rdata_a(rdata_a1), .resp_a(resp_a1),
      .address_b(32'h0), .read_b(1'b0), .write(1'b0), .data_mbe(4'h0),
      .wdata(32'h0), .rdata_b(rdata_b1), .resp_b(resp_b1), .proto_err(perr1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] mbe);
      logic [31:0] mask;
      mask = {{8{mbe[3]}}, {8{mbe[2]}}, {8{mbe[1]}}, {8{mbe[0]}}};
      return (old & ~mask) | (wd & mask);
   endfunction

   // Drive one transaction on each enabled port, hold until resp, scramble the sampled-once inputs.
   task automatic xact(input bit en_a, input logic [31:0] addr_a, input bit en_b, input bit st, input bit both,
                       input logic [31:0] addr_b, input logic [3:0] mbe, input logic [31:0] wd,
                       output int lat_a, output logic [31:0] rd_a, output int lat_b, output logic [31:0] rd_b);
      lat_a = -1; lat_b = -1; rd_a = '0; rd_b = '0;
      address_a = addr_a; read_a = en_a;
      address_b = addr_b; read_b = en_b && (!st || both); write = en_b && st;
      data_mbe = mbe; wdata = wd;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 1) begin
            address_a = $urandom; address_b = $urandom; data_mbe = 4'($urandom); wdata = $urandom;
         end
         if (resp_a && lat_a < 0) begin lat_a = en_a ? k : 100; rd_a = rdata_a; read_a = 1'b0; end
         if (resp_b && lat_b < 0) begin lat_b = en_b ? k : 100; rd_b = rdata_b; read_b = 1'b0; write = 1'b0; end
         if ((lat_a >= 0 || !en_a) && (lat_b >= 0 || !en_b)) break;
      end
      read_a = 1'b0; read_b = 1'b0; write = 1'b0;
      tick();
   endtask

   task automatic do_b(input bit st, input logic [31:0] addr, input logic [3:0] mbe, input logic [31:0] wd, input string tag);
      int la, lb, idx;
      logic [31:0] ra, rb, exp;
      idx = int'((addr >> 2) % DEPTH);
      if (st) mdl[idx] = merge(mdl[idx], wd, mbe);
      exp = st ? 32'h0 : mdl[idx];
      xact(1'b0, 32'h0, 1'b1, st, 1'b0, addr, mbe, wd, la, ra, lb, rb);
      chk({tag, "_lat"}, lb, LAT);
      chk({tag, "_data"}, rb, exp);
   endtask

   initial begin
      int la, lb;
      logic [31:0] ra, rb;
      foreach (mdl[i]) mdl[i] = '0;

      tick(); tick();
      chk("rst_resp_a", resp_a, 0);
      chk("rst_resp_b", resp_b, 0);
      chk("rst_rdata_a", rdata_a, 0);
      chk("rst_rdata_b", rdata_b, 0);
      chk("rst_proto_err", proto_err, 0);
      rst = 1'b0;
      tick();

      do_b(1'b1, 32'h40, 4'hF, 32'hDEADBEEF, "pre_10");
      do_b(1'b1, 32'h80, 4'hF, 32'h11223344, "pre_20");

      address_a = 32'h40; read_a = 1'b1;
      tick();
      chk("fetch_c1_resp", resp_a, 0);
      tick();
      chk("fetch_c2_resp", resp_a, 1);
      chk("fetch_c2_data", rdata_a, 32'hDEADBEEF);
      read_a = 1'b0;
      tick();
      chk("fetch_c3_resp", resp_a, 0);
      chk("fetch_c3_data", rdata_a, 0);
      tick();

      do_b(1'b1, 32'h80, 4'b0101, 32'hAABBCCDD, "st_mbe");
      chk("st_mbe_once", resp_b, 0);
      do_b(1'b0, 32'h80, 4'hF, 32'h0, "ld_mbe");
      chk("ld_mbe_model", mdl[32'h20], 32'h11BB33DD);

      do_b(1'b1, 32'h100, 4'hF, 32'h01020304, "pre_40");
      mdl[32'h40] = merge(mdl[32'h40], 32'hA0B0C0D0, 4'b1100);
      xact(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h100, 4'b1100, 32'hA0B0C0D0, la, ra, lb, rb);
      chk("coll_lat_a", la, LAT);
      chk("coll_lat_b", lb, LAT);
      chk("coll_data_a", ra, 32'hA0B00304);
      chk("coll_data_b", rb, 0);

      do_b(1'b0, 32'h40 + 4 * DEPTH, 4'hF, 32'h0, "wrap");

      for (int i = 0; i < 8; i++) do_b(1'b1, 32'(i * 4), 4'hF, $urandom, "pre_rnd");
      for (int it = 0; it < 40; it++) begin
         bit ea, eb, st;
         int ia, ib;
         logic [31:0] aa, ab, wd, exa, exb;
         logic [3:0] m;
         ea = 1'($urandom); eb = ea ? 1'($urandom) : 1'b1; st = 1'($urandom);
         ia = $urandom_range(0, 7);
         ib = ($urandom_range(0, 2) == 0) ? ia : $urandom_range(0, 7);
         aa = ($urandom << 12) | 32'(ia << 2) | $urandom_range(0, 3);
         ab = ($urandom << 12) | 32'(ib << 2) | $urandom_range(0, 3);
         wd = $urandom; m = 4'($urandom);
         if (eb && st) mdl[ib] = merge(mdl[ib], wd, m);
         exa = mdl[ia];
         exb = (eb && !st) ? mdl[ib] : 32'h0;
         xact(ea, aa, eb, st, 1'b0, ab, m, wd, la, ra, lb, rb);
         chk("rnd_lat_a", la, ea ? LAT : -1);
         chk("rnd_lat_b", lb, eb ? LAT : -1);
         if (ea) chk("rnd_data_a", ra, exa);
         if (eb) chk("rnd_data_b", rb, exb);
      end

      chk("perr_clean", proto_err, 0);
      mdl[32'h60] = 32'h5A5A5A5A;
      xact(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h180, 4'hF, 32'h5A5A5A5A, la, ra, lb, rb);
      chk("rw_both_lat", lb, LAT);
      chk("rw_both_perr", proto_err, 1);
      do_b(1'b0, 32'h180, 4'hF, 32'h0, "rw_both_ld");
      chk("perr_sticky", proto_err, 1);

      rst = 1'b1;
      tick();
      chk("perr_rst", proto_err, 0);
      rst = 1'b0;
      tick();

      address_a = 32'h40; read_a = 1'b1;
      tick();
      chk("drop_perr0", proto_err, 0);
      read_a = 1'b0;
      tick();
      chk("drop_resp", resp_a, 1);
      chk("drop_perr1", proto_err, 1);
      tick();

      address_b = 32'h40; wdata = 32'h0; data_mbe = 4'hF; write = 1'b1;
      tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_resp_b", resp_b, 0);
      chk("arst_rdata_b", rdata_b, 0);
      chk("arst_perr", proto_err, 0);
      write = 1'b0;
      tick();
      chk("arst_nopulse1", resp_b, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("arst_nopulse2", resp_b, 0);
      do_b(1'b0, 32'h40, 4'hF, 32'h0, "arst_unchanged");

      read_a1 = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("lat1_resp", resp_a1, (k % 2 == 1) ? 1 : 0);
      end
      read_a1 = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
